// File: rtl/opcodes.sv
// rtl/opcodes.sv - shared loader state encoding and frame header default
package opcodes;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

    localparam logic [7:0] LOAD_HEADER = 8'hA5;

endpackage

// File: rtl/load_timer.sv
// rtl/load_timer.sv - idle-gap counter that flags when a frame stalls too long
module load_timer #(
    parameter int TimeoutCycles = 1_000_000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Enable,
    input  logic Clear,
    output logic Expired
);

    localparam int W = $clog2(TimeoutCycles + 1);
    localparam logic [W-1:0] LIMIT = W'(TimeoutCycles);

    logic [W-1:0] count;

    // Saturates at the limit so a stalled frame keeps signalling expiry.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (Clear || !Enable) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + W'(1);
        end
    end

    assign Expired = Enable && (count == LIMIT);

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte stream to program memory writer with checksum and CPU hold
module prog_loader
    import opcodes::*;
#(
    parameter int n = 8,
    parameter logic [n-1:0] Header = n'(LOAD_HEADER),
    parameter int TimeoutCycles = 1_000_000
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         RxValid,
    input  logic [n-1:0] RxData,
    output logic         WrEn,
    output logic [n-1:0] WrAddr,
    output logic [n-1:0] WrData,
    output logic         CpuHold,
    output logic         Done,
    output logic         Error
);

    localparam logic [n:0] FULL_FRAME = {1'b1, {n{1'b0}}};

    loader_state_t state;
    logic [n-1:0]  addr;
    logic [n-1:0]  sum;
    logic [n:0]    remaining;
    logic          timer_en;
    logic          expired;

    assign timer_en = (state == COUNT) || (state == DATA) || (state == CHECK);

    load_timer #(.TimeoutCycles(TimeoutCycles)) u_timer (
        .Clock   (Clock),
        .Reset   (Reset),
        .Enable  (timer_en),
        .Clear   (RxValid),
        .Expired (expired)
    );

    // A strobe in the expiry cycle takes priority, so the timeout is discarded.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            addr      <= '0;
            sum       <= '0;
            remaining <= '0;
            WrEn      <= 1'b0;
            WrAddr    <= '0;
            WrData    <= '0;
            CpuHold   <= 1'b1;
            Done      <= 1'b0;
            Error     <= 1'b0;
        end else begin
            WrEn <= 1'b0;
            case (state)
                IDLE: begin
                    if (RxValid && RxData == Header) state <= COUNT;
                end
                COUNT: begin
                    if (RxValid) begin
                        remaining <= (RxData == '0) ? FULL_FRAME : {1'b0, RxData};
                        addr      <= '0;
                        sum       <= '0;
                        state     <= DATA;
                    end else if (expired) begin
                        state <= ERROR;
                        Error <= 1'b1;
                    end
                end
                DATA: begin
                    if (RxValid) begin
                        WrEn      <= 1'b1;
                        WrAddr    <= addr;
                        WrData    <= RxData;
                        sum       <= sum + RxData;
                        addr      <= addr + n'(1);
                        remaining <= remaining - (n+1)'(1);
                        if (remaining == (n+1)'(1)) state <= CHECK;
                    end else if (expired) begin
                        state <= ERROR;
                        Error <= 1'b1;
                    end
                end
                CHECK: begin
                    if (RxValid) begin
                        if (RxData == sum) begin
                            state   <= DONE;
                            Done    <= 1'b1;
                            CpuHold <= 1'b0;
                        end else begin
                            state <= ERROR;
                            Error <= 1'b1;
                        end
                    end else if (expired) begin
                        state <= ERROR;
                        Error <= 1'b1;
                    end
                end
                DONE: begin
                    if (RxValid && RxData == Header) begin
                        state   <= COUNT;
                        Done    <= 1'b0;
                        CpuHold <= 1'b1;
                    end
                end
                ERROR: begin
                    if (RxValid && RxData == Header) begin
                        state <= COUNT;
                        Error <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed-vector bench for prog_loader
module tb_prog_loader;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_hold;
    logic       done;
    logic       error;

    int vectors = 0;
    int miscompares = 0;

    prog_loader #(.n(8), .Header(8'hA5), .TimeoutCycles(T)) dut (
        .Clock   (clk),
        .Reset   (rst),
        .RxValid (rx_valid),
        .RxData  (rx_data),
        .WrEn    (wr_en),
        .WrAddr  (wr_addr),
        .WrData  (wr_data),
        .CpuHold (cpu_hold),
        .Done    (done),
        .Error   (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Strobe one byte at the next rising edge; return at the following falling edge.
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_wr(input string tag, input logic [7:0] b, input logic [7:0] a);
        send(b);
        check({tag, " wren"}, 32'(wr_en), 32'd1);
        check({tag, " addr"}, 32'(wr_addr), 32'(a));
        check({tag, " data"}, 32'(wr_data), 32'(b));
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic h);
        check({tag, " done"}, 32'(done), 32'(d));
        check({tag, " error"}, 32'(error), 32'(e));
        check({tag, " hold"}, 32'(cpu_hold), 32'(h));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rst      = 1'b1;
        idle(2);
        check("reset wren", 32'(wr_en), 32'd0);
        check("reset addr", 32'(wr_addr), 32'd0);
        check("reset data", 32'(wr_data), 32'd0);
        check_status("reset", 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Clean load
        send(8'hA5);
        send(8'h03);
        check("clean count wren", 32'(wr_en), 32'd0);
        send_wr("clean b0", 8'h11, 8'h00);
        send_wr("clean b1", 8'h22, 8'h01);
        send_wr("clean b2", 8'h33, 8'h02);
        check_status("clean pre", 1'b0, 1'b0, 1'b1);
        send(8'h66);
        check("clean sum wren", 32'(wr_en), 32'd0);
        check_status("clean", 1'b1, 1'b0, 1'b0);

        // Reload from DONE
        send(8'hA5);
        check_status("reload hdr", 1'b0, 1'b0, 1'b1);
        send(8'h01);
        send_wr("reload b0", 8'h5A, 8'h00);
        send(8'h5A);
        check_status("reload", 1'b1, 1'b0, 1'b0);

        // Bad checksum
        do_reset();
        send(8'hA5);
        send(8'h02);
        send_wr("bad b0", 8'h01, 8'h00);
        send_wr("bad b1", 8'h02, 8'h01);
        send(8'h04);
        check_status("bad", 1'b0, 1'b1, 1'b1);
        send(8'h03);
        check_status("bad ignore", 1'b0, 1'b1, 1'b1);

        // Noise in IDLE, then timeout
        do_reset();
        send(8'h00);
        check("noise00 wren", 32'(wr_en), 32'd0);
        send(8'hFF);
        check("noiseFF wren", 32'(wr_en), 32'd0);
        check_status("noise", 1'b0, 1'b0, 1'b1);
        send(8'hA5);
        send(8'h02);
        send_wr("to b0", 8'h10, 8'h00);
        idle(T);
        check_status("to before", 1'b0, 1'b0, 1'b1);
        idle(1);
        check_status("to expired", 1'b0, 1'b1, 1'b1);

        // Strobe landing on the expiry cycle is processed
        send(8'hA5);
        check("rearm error", 32'(error), 32'd0);
        send(8'h02);
        send_wr("exp b0", 8'h10, 8'h00);
        idle(T);
        send_wr("exp b1", 8'h20, 8'h01);
        check("exp error", 32'(error), 32'd0);
        send(8'h30);
        check_status("exp", 1'b1, 1'b0, 1'b0);

        // Full 256-byte frame
        do_reset();
        send(8'hA5);
        send(8'h00);
        for (int i = 0; i < 256; i++) send_wr("full", 8'(i), 8'(i));
        check_status("full pre", 1'b0, 1'b0, 1'b1);
        send(8'h80);
        check("full sum wren", 32'(wr_en), 32'd0);
        check_status("full", 1'b1, 1'b0, 1'b0);

        // Reset mid-DATA is asynchronous
        do_reset();
        send(8'hA5);
        send(8'h03);
        send_wr("mid b0", 8'h01, 8'h00);
        send_wr("mid b1", 8'h02, 8'h01);
        #2 rst = 1'b1;
        #1;
        check("mid wren", 32'(wr_en), 32'd0);
        check("mid addr", 32'(wr_addr), 32'd0);
        check("mid data", 32'(wr_data), 32'd0);
        check_status("mid rst", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'hA5);
        send(8'h01);
        send_wr("mid2 b0", 8'h7E, 8'h00);
        send(8'h7E);
        check_status("mid2", 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader: the write-side counterpart of the CPU's instruction/data RAM reads. It accepts a framed byte stream from a byte receiver, writes the payload into program memory from address 0 upward, and checks a modulo-256 checksum. It holds the CPU in reset until a load completes cleanly. It sits beside `cpu` at top level; its write port shares the `ram` address/data path while the CPU is held.

## Interface
Parameters:
- `n`, 8: memory address and data width; the byte stream is n bits wide.
- `Header`, 8'hA5: frame start byte.
- `TimeoutCycles`, 1_000_000: maximum idle clocks between bytes inside a frame.

Ports:
- `Clock`  in  1: single system clock; all state updates on rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `RxValid`  in  1: one-cycle strobe; `RxData` is valid this cycle.
- `RxData`  in  n: received byte.
- `WrEn`  out  1: memory write strobe, one cycle per payload byte.
- `WrAddr`  out  n: memory write address.
- `WrData`  out  n: memory write data.
- `CpuHold`  out  1: 1 holds the CPU in reset. Top level drives `cpu.nReset = ~CpuHold & ~Reset`.
- `Done`  out  1: the last frame loaded and passed its checksum.
- `Error`  out  1: the last frame failed its checksum or timed out.

## Operation
- Frame format: `Header`, count byte C, payload bytes, checksum byte K.
  - C = 0 means 2^n payload bytes; otherwise there are C payload bytes.
  - K = sum of payload bytes mod 2^n.
- States:
  - IDLE: on `RxValid`, if `RxData==Header` go to COUNT; any other byte is ignored.
  - COUNT: on `RxValid`, latch Remaining = C (0 means 2^n); clear Addr and Sum; go to DATA.
  - DATA: on `RxValid`, register a write of `RxData` to Addr; Sum += `RxData` (n-bit wrap); Addr += 1; Remaining -= 1. When Remaining reaches 0, go to CHECK.
  - CHECK: on `RxValid`, go to DONE if `RxData==Sum`, otherwise go to ERROR.
  - DONE: `Done`=1 and `CpuHold`=0. A `Header` byte re-enters COUNT: `Done`=0 and `CpuHold`=1 on the next cycle.
  - ERROR: `Error`=1 and `CpuHold`=1. A `Header` byte re-enters COUNT and clears `Error`. Other bytes are ignored.
- Timeout:
  - The idle counter runs only in COUNT, DATA and CHECK, and clears on every `RxValid`.
  - When it reaches `TimeoutCycles`, go to ERROR.
  - If `RxValid` arrives in the same cycle the counter expires, the byte is processed and the timeout is discarded.
- Addr wraps from 2^n-1 to 0. This only occurs at the end of a 2^n-byte frame, and no further write follows.
- `CpuHold` falls only on the transition into DONE.

## Timing
- Reset values: state IDLE; `WrEn`=0, `WrAddr`=0, `WrData`=0, `CpuHold`=1, `Done`=0, `Error`=0; Sum, Addr, Remaining and the idle counter all 0.
- Write latency: `RxValid` of a payload byte at edge k causes `WrEn`=1 with that byte and address during the cycle after edge k. `WrEn` lasts exactly one cycle.
- Back-to-back `RxValid` on consecutive cycles is supported at full rate, with one write per cycle.
- `Done`, `Error` and `CpuHold` change one cycle after the `RxValid` of the checksum byte, or after the timeout edge.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). Memory bytes already written are not restored. The next frame must start with `Header`.
- No backpressure: the receiver must not strobe faster than once per cycle.

## Structure
- Shared package `opcodes`:
  - `loader_state_t` enum (IDLE, COUNT, DATA, CHECK, DONE, ERROR).
  - Default `LOAD_HEADER` constant = 8'hA5.
- Sub-module `load_timer`: a loadable idle counter.
  - Inputs: `Clock`, `Reset`, `Enable`, `Clear`.
  - Output: `Expired`.
  - Width `$clog2(TimeoutCycles+1)`.
- The RAM write-port address/data mux, selected by `CpuHold`, lives at top level, not in this block.

## Test plan
- Clean load: A5, 03, 11, 22, 33, 66 → writes (0,11), (1,22), (2,33), each one cycle after its strobe; `Done`=1, `CpuHold`=0 one cycle after 66.
- Bad checksum: A5, 02, 01, 02, 04 → two writes; `Error`=1, `CpuHold`=1, `Done`=0.
- Noise and timeout: bytes 00, FF in IDLE cause no effect. Then A5, 02, 10, followed by `TimeoutCycles` idle clocks → ERROR. A `RxValid` landing on the expiry cycle instead writes the byte.
- Full frame: A5, 00, then 256 bytes i=0..255, then checksum 80 → 256 writes with addr 0..FF and data i; Addr wraps to 0; `Done`=1.
- Reset mid-DATA: assert `Reset` after the second payload byte → outputs return to reset values; A5, 01, 7E, 7E then loads cleanly; `Done`=1.
- Reload from DONE: after a clean load, send A5 → `Done`=0 and `CpuHold`=1 on the next cycle; a second clean frame then completes.
